// File: rtl/weight_loader.sv
// Streams signed weight words from a host into a layered weight store, one
// assembled row per write strobe. Optional frame checksum: LOADER_CHECKSUM_EN.
module weight_loader #(
    parameter int data_size  = 16,
    parameter int size       = 3,
    parameter int layer_size = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [data_size-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [31:0]                 write_layer_index,
    output logic [31:0]                 write_row_index,
    output logic [data_size*size-1:0]   write_data,
    output logic                        is_write,
    output logic                        busy,
    output logic                        done,
    output logic                        checksum_err
);

    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam int LW = $clog2(layer_size + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [CW-1:0]               r_col;
    logic [CW-1:0]               r_row;
    logic [LW-1:0]               r_layer;
    logic [data_size*size-1:0]   r_wdata;

    logic w_accept;
    logic w_last_col;
    logic w_last_row;
    logic w_last_layer;
    logic w_in_ready;

    assign w_last_col   = (r_col == CW'(size - 1));
    assign w_last_row   = (r_row == CW'(size - 1));
    assign w_last_layer = (r_layer == LW'(layer_size - 1));

    // abort masks the handshake so no word is consumed in the cycle it is raised
`ifdef LOADER_CHECKSUM_EN
    assign w_in_ready = !abort && ((r_state == S_LOAD) || (r_state == S_CHECK));
`else
    assign w_in_ready = !abort && (r_state == S_LOAD);
`endif
    assign w_accept = in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_accept && w_last_col) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_last_row && w_last_layer) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_FINISH;
`endif
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_accept) w_next = S_FINISH;
`else
                w_next = S_IDLE;
`endif
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_layer <= '0;
            r_wdata <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_col   <= '0;
                r_row   <= '0;
                r_layer <= '0;
            end
        end else if (!abort) begin
            if ((r_state == S_LOAD) && w_accept) begin
                for (int unsigned k = 0; k < size; k++) begin
                    if (r_col == CW'(k)) r_wdata[(size-k)*data_size-1 -: data_size] <= in_data;
                end
                r_col <= r_col + CW'(1);
            end
            if (r_state == S_WRITE) begin
                r_col <= '0;
                if (w_last_row) begin
                    r_row   <= '0;
                    r_layer <= r_layer + LW'(1);
                end else begin
                    r_row <= r_row + CW'(1);
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [data_size-1:0] r_sum;
    logic                 r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_sum <= '0;
                r_err <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_state == S_LOAD) r_sum <= r_sum + in_data;
            if ((r_state == S_CHECK) && (in_data != r_sum)) r_err <= 1'b1;
        end
    end

    assign checksum_err = r_err;
`else
    assign checksum_err = 1'b0;
`endif

    assign in_ready          = w_in_ready;
    assign is_write          = (r_state == S_WRITE) && !abort;
    assign done              = (r_state == S_FINISH) && !abort;
    assign busy              = (r_state != S_IDLE);
    assign write_data        = r_wdata;
    assign write_row_index   = 32'(r_row);
    assign write_layer_index = 32'(r_layer);

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader at default parameters; checksum frames
// are exercised when LOADER_CHECKSUM_EN is defined.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] write_layer_index;
    logic [31:0] write_row_index;
    logic [47:0] write_data;
    logic        is_write;
    logic        busy;
    logic        done;
    logic        checksum_err;

    weight_loader #(.data_size(16), .size(3), .layer_size(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .write_layer_index(write_layer_index), .write_row_index(write_row_index),
        .write_data(write_data), .is_write(is_write), .busy(busy),
        .done(done), .checksum_err(checksum_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] layer;
        logic [31:0] row;
        logic [47:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        bit gap;
        int exp_writes;
        int exp_done;
    } scen_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc_cyc = -10;
    int done_cnt = 0;
    int done_cyc = 0;
    bit prev_wr = 1'b0;
    wr_t wr_q[$];
    wr_t exp_tab[15];
    scen_t scen[2];
    logic [15:0] csum_word = 16'h0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: acceptance sampled at negedge takes effect on the following posedge
    always @(negedge clk) begin
        cyc++;
        if (is_write === 1'b1) begin
            chk("wr_latency", 64'(cyc - last_acc_cyc), 64'd1);
            chk("wr_one_cycle", {63'd0, prev_wr}, 64'd0);
            wr_q.push_back('{write_layer_index, write_row_index, write_data, cyc});
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_wr = (is_write === 1'b1);
        if (in_valid && in_ready === 1'b1) begin
            acc_cnt++;
            if (acc_cnt % 3 == 0) last_acc_cyc = cyc;
        end
    end

    task automatic push_word(input logic [15:0] w, input bit gap);
        bit acc;
        acc = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        acc_cnt = 0;
        done_cnt = 0;
        wr_q.delete();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        for (int t = 0; t < n; t++) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit gap);
        do_start();
        @(negedge clk);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        for (int w = 1; w <= 45; w++) push_word(16'(w), gap);
`ifdef LOADER_CHECKSUM_EN
        push_word(csum_word, gap);
`endif
        for (int t = 0; t < 50 && done_cnt == 0; t++) @(posedge clk);
        wait_idle(4);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int n = 0; n < 15; n++) begin
            exp_tab[n].layer = 32'(n / 3);
            exp_tab[n].row   = 32'(n % 3);
            exp_tab[n].data  = {16'(3*n+1), 16'(3*n+2), 16'(3*n+3)};
            exp_tab[n].cyc   = 0;
        end
        scen[0] = '{1'b0, 15, 1};
        scen[1] = '{1'b1, 15, 1};

        // Reset state
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_is_write", {63'd0, is_write}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        chk("rst_idx", {write_layer_index, write_row_index}, 64'd0);
        chk("rst_cerr", {63'd0, checksum_err}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle(2);
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd0);

        // Full frames: continuous and gapped in_valid
        csum_word = 16'h040B;
        for (int s = 0; s < 2; s++) begin
            run_frame(scen[s].gap);
            chk("wr_count", 64'(wr_q.size()), 64'(scen[s].exp_writes));
            chk("done_count", 64'(done_cnt), 64'(scen[s].exp_done));
            for (int n = 0; n < 15 && n < wr_q.size(); n++) begin
                chk("wr_layer", 64'(wr_q[n].layer), 64'(exp_tab[n].layer));
                chk("wr_row", 64'(wr_q[n].row), 64'(exp_tab[n].row));
                chk("wr_data", 64'(wr_q[n].data), 64'(exp_tab[n].data));
            end
            if (wr_q.size() == 15) begin
                chk("first_data", 64'(wr_q[0].data), 64'h0000_0001_0002_0003);
                chk("last_data", 64'(wr_q[14].data), 64'h0000_002B_002C_002D);
                chk("last_idx", {wr_q[14].layer, wr_q[14].row}, {32'd4, 32'd2});
`ifndef LOADER_CHECKSUM_EN
                chk("done_after_last_wr", 64'(done_cyc - wr_q[14].cyc), 64'd1);
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            chk("cerr_good_sum", {63'd0, checksum_err}, 64'd0);
`endif
        end

        // Abort after 4 words: one write, IDLE next cycle, no done
        do_start();
        for (int w = 1; w <= 4; w++) push_word(16'(w), 1'b0);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        wait_idle(10);
        chk("abort_wr_count", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0)
            chk("abort_wr0", {wr_q[0].layer[7:0], wr_q[0].row[7:0], wr_q[0].data}, {8'd0, 8'd0, 48'h0001_0002_0003});
        chk("abort_done", 64'(done_cnt), 64'd0);

        // Abort raised in the WRITE cycle suppresses the strobe
        do_start();
        for (int w = 1; w <= 3; w++) push_word(16'(w), 1'b0);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_wr_suppress", {63'd0, is_write}, 64'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(5);
        chk("abort_wr_count2", 64'(wr_q.size()), 64'd0);
        chk("abort_done2", 64'(done_cnt), 64'd0);

        // Asynchronous reset between word 2 and word 3
        do_start();
        for (int w = 1; w <= 2; w++) push_word(16'(w), 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("arst_wdata", 64'(write_data), 64'd0);
        chk("arst_idx", {write_layer_index, write_row_index}, 64'd0);
        chk("arst_strobes", {61'd0, is_write, done, checksum_err}, 64'd0);
        wait_idle(2);
        rst_n = 1'b1;
        wait_idle(5);
        chk("arst_wr_count", 64'(wr_q.size()), 64'd0);
        chk("arst_busy_after", {63'd0, busy}, 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: flag sets, holds in IDLE, clears on next start
        csum_word = 16'h040C;
        run_frame(1'b0);
        chk("cerr_bad_sum", {63'd0, checksum_err}, 64'd1);
        wait_idle(5);
        chk("cerr_held", {63'd0, checksum_err}, 64'd1);
        do_start();
        @(negedge clk);
        chk("cerr_cleared", {63'd0, checksum_err}, 64'd0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
